fpu_issue_queue: RTL and testbench

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

---
 rtl/fpu_issue_queue_if.sv | 27 ++
 rtl/fpu_issue_queue.sv | 135 +++++++++++++
 tb/tb_fpu_issue_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_queue_if.sv
// Handshake bundle between the FP front-end, the issue queue and the FPU decode stage.
// master: environment side (front-end pushes, FPU reports hazard, flush source).
// slave : queue side (accepts pushes, presents the head instruction to the FPU).
interface fpu_issue_queue_if;
  // Front-end push channel
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_intop;
  // Pipeline flush (mispredict / exception)
  logic        flush;
  // FPU issue channel
  logic [31:0] fpu_inst;
  logic        fpu_is_legl;
  logic [31:0] fpu_from_intreg;
  logic        fpu_hazard;

  modport master (
    output in_valid, in_inst, in_intop, flush, fpu_hazard,
    input  in_ready, fpu_inst, fpu_is_legl, fpu_from_intreg
  );

  modport slave (
    input  in_valid, in_inst, in_intop, flush, fpu_hazard,
    output in_ready, fpu_inst, fpu_is_legl, fpu_from_intreg
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// FP instruction issue queue: circular FIFO of {inst, intop} pairs feeding the FPU decode stage.
// Latency: 1 cycle push-to-present; 0 cycles for an empty queue when FPU_ISSUE_BYPASS_EN is defined.
// Backpressure: in_ready = (count < DEPTH) from registered state only; head held while fpu_hazard is set.
//
// Ports:
//   clk, rst      - single clock, asynchronous active-high reset
//   bus (slave)   - in_valid/in_ready/in_inst/in_intop push channel, flush,
//                   fpu_inst/fpu_is_legl/fpu_from_intreg issue channel, fpu_hazard from the FPU
//   count         - current occupancy
//   stall_cycles  - saturating count of cycles the presented instruction was held by a hazard
// Optional build macro: FPU_ISSUE_BYPASS_EN (combinational bypass of an empty queue).
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fpu_issue_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Storage is intentionally not reset; only pointers/count qualify its contents.
  logic [31:0]   inst_mem  [DEPTH];
  logic [31:0]   intop_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [CW-1:0] stall_q;

  logic          non_empty;
  logic          presented;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   head_inst;
  logic [31:0]   head_intop;

  assign non_empty  = (count_q != '0);
  assign head_inst  = inst_mem[rd_ptr];
  assign head_intop = intop_mem[rd_ptr];

  // Registered-only ready: a full queue refuses a push even when it pops that cycle.
  assign bus.in_ready = (count_q < FULL);

`ifdef FPU_ISSUE_BYPASS_EN
  logic bypass;

  // Empty queue: forward the incoming instruction straight to the FPU.
  assign bypass    = ~non_empty & bus.in_valid;
  assign presented = non_empty | bypass;

  always_comb begin
    bus.fpu_inst        = 32'h0;
    bus.fpu_from_intreg = 32'h0;
    if (non_empty) begin
      bus.fpu_inst        = head_inst;
      bus.fpu_from_intreg = head_intop;
    end else if (bypass) begin
      bus.fpu_inst        = bus.in_inst;
      bus.fpu_from_intreg = bus.in_intop;
    end
  end

  // rst gates issue so a bypassed instruction cannot leak out during reset.
  assign issue = presented & ~bus.fpu_hazard & ~bus.flush & ~rst;
  // Only a queued head consumes storage; a bypassed issue never touches the FIFO.
  assign pop   = issue & non_empty;
  // A bypassed instruction that issued is done; one that stalled is queued normally.
  assign push  = bus.in_valid & bus.in_ready & ~bus.flush & ~(bypass & issue);
`else
  assign presented = non_empty;

  always_comb begin
    bus.fpu_inst        = 32'h0;
    bus.fpu_from_intreg = 32'h0;
    if (non_empty) begin
      bus.fpu_inst        = head_inst;
      bus.fpu_from_intreg = head_intop;
    end
  end

  assign issue = presented & ~bus.fpu_hazard & ~bus.flush & ~rst;
  assign pop   = issue;
  assign push  = bus.in_valid & bus.in_ready & ~bus.flush;
`endif

  assign bus.fpu_is_legl = issue;
  assign count           = count_q;
  assign stall_cycles    = stall_q;

  // Control state: pointers, occupancy and hazard-stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      // Saturating: sticks at all-ones rather than wrapping.
      if (presented && bus.fpu_hazard && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end

      if (bus.flush) begin
        // Flush drops everything, including a push offered in the same cycle.
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry storage; push already excludes flush cycles.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr]  <= bus.in_inst;
      intop_mem[wr_ptr] <= bus.in_intop;
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed self-checking bench for fpu_issue_queue (DEPTH=4, CW=16).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_fpu_issue_queue;

  logic        clk;
  logic        rst;
  logic [2:0]  count;
  logic [15:0] stall_cycles;

  int checks;
  int passes;
  int fails;

  fpu_issue_queue_if qif ();

  fpu_issue_queue #(.DEPTH(4), .CW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (qif),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] cvec [5];
    checks = 0;
    passes = 0;
    fails  = 0;
    cvec[0] = 32'h0000_1053;
    cvec[1] = 32'h0000_2053;
    cvec[2] = 32'h0000_3053;
    cvec[3] = 32'h0000_4053;
    cvec[4] = 32'h0000_5053;

    rst            = 1'b1;
    qif.in_valid   = 1'b0;
    qif.in_inst    = 32'h0;
    qif.in_intop   = 32'h0;
    qif.flush      = 1'b0;
    qif.fpu_hazard = 1'b0;
    #2;
    check("rst_in_ready", 32'(qif.in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_legl", 32'(qif.fpu_is_legl), 32'd0);
    check("rst_inst", qif.fpu_inst, 32'h0);
    check("rst_intop", qif.fpu_from_intreg, 32'h0);
    cyc();
    rst = 1'b0;

`ifndef FPU_ISSUE_BYPASS_EN
    // A: three back-to-back pushes, no hazard
    qif.in_valid = 1'b1; qif.in_inst = 32'h00A28553; qif.in_intop = 32'h11; #1;
    check("A_empty_legl", 32'(qif.fpu_is_legl), 32'd0);
    check("A_empty_count", 32'(count), 32'd0);
    cyc();
    qif.in_inst = 32'h08A28553; qif.in_intop = 32'h22; #1;
    check("A_issue0_inst", qif.fpu_inst, 32'h00A28553);
    check("A_issue0_intop", qif.fpu_from_intreg, 32'h11);
    check("A_issue0_legl", 32'(qif.fpu_is_legl), 32'd1);
    check("A_issue0_count", 32'(count), 32'd1);
    cyc();
    qif.in_inst = 32'h10A28553; qif.in_intop = 32'h33; #1;
    check("A_issue1_inst", qif.fpu_inst, 32'h08A28553);
    check("A_issue1_legl", 32'(qif.fpu_is_legl), 32'd1);
    check("A_issue1_count", 32'(count), 32'd1);
    cyc();
    qif.in_valid = 1'b0; #1;
    check("A_issue2_inst", qif.fpu_inst, 32'h10A28553);
    check("A_issue2_intop", qif.fpu_from_intreg, 32'h33);
    check("A_issue2_legl", 32'(qif.fpu_is_legl), 32'd1);
    cyc();
    #1;
    check("A_drained_count", 32'(count), 32'd0);
    check("A_drained_inst", qif.fpu_inst, 32'h0);

    // B: head held by hazard for three cycles
    qif.in_valid = 1'b1; qif.in_inst = 32'h00A28553; qif.in_intop = 32'h44; qif.fpu_hazard = 1'b1;
    cyc();
    qif.in_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("B_hold_inst", qif.fpu_inst, 32'h00A28553);
      check("B_hold_legl", 32'(qif.fpu_is_legl), 32'd0);
      cyc();
    end
    qif.fpu_hazard = 1'b0; #1;
    check("B_stall_cycles", 32'(stall_cycles), 32'd3);
    check("B_release_legl", 32'(qif.fpu_is_legl), 32'd1);
    check("B_release_inst", qif.fpu_inst, 32'h00A28553);
    cyc();
    #1;
    check("B_after_count", 32'(count), 32'd0);

    // C: fill under hazard; pointers wrap here
    qif.fpu_hazard = 1'b1; qif.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      qif.in_inst = cvec[k]; qif.in_intop = 32'(k); #1;
      check("C_ready_before_full", 32'(qif.in_ready), 32'd1);
      cyc();
    end
    qif.in_inst = cvec[4]; #1;
    check("C_full_ready", 32'(qif.in_ready), 32'd0);
    check("C_full_count", 32'(count), 32'd4);
    check("C_full_head", qif.fpu_inst, cvec[0]);
    cyc();
    check("C_fifth_held_count", 32'(count), 32'd4);
    qif.in_valid = 1'b0; qif.fpu_hazard = 1'b0; #1;
    check("C_pop_when_full_legl", 32'(qif.fpu_is_legl), 32'd1);
    check("C_pop_when_full_ready", 32'(qif.in_ready), 32'd0);
    cyc();
    check("C_after_pop_count", 32'(count), 32'd3);
    check("C_after_pop_head", qif.fpu_inst, cvec[1]);

    // D: flush with a concurrent push at count = 3
    qif.flush = 1'b1; qif.in_valid = 1'b1; qif.in_inst = 32'hDEAD0053; #1;
    check("D_flush_legl", 32'(qif.fpu_is_legl), 32'd0);
    check("D_stall_total", 32'(stall_cycles), 32'd7);
    cyc();
    qif.flush = 1'b0; qif.in_valid = 1'b0; #1;
    check("D_count", 32'(count), 32'd0);
    check("D_no_issue", 32'(qif.fpu_is_legl), 32'd0);
    check("D_inst_zero", qif.fpu_inst, 32'h0);
    cyc();
    check("D_still_empty", 32'(count), 32'd0);

    // E: asynchronous reset with two entries queued
    qif.fpu_hazard = 1'b1; qif.in_valid = 1'b1; qif.in_inst = 32'hE0000053;
    cyc();
    qif.in_inst = 32'hE1000053;
    cyc();
    qif.in_valid = 1'b0; #1;
    check("E_count_before", 32'(count), 32'd2);
    qif.fpu_hazard = 1'b0; qif.in_valid = 1'b1; #2;
    rst = 1'b1; #1;
    check("E_rst_ready", 32'(qif.in_ready), 32'd1);
    check("E_rst_count", 32'(count), 32'd0);
    check("E_rst_stall", 32'(stall_cycles), 32'd0);
    check("E_rst_legl", 32'(qif.fpu_is_legl), 32'd0);
    cyc();
    check("E_rst_hold_count", 32'(count), 32'd0);
    rst = 1'b0; qif.in_inst = 32'hF0000053; qif.in_intop = 32'h55;
    cyc();
    qif.in_valid = 1'b0; #1;
    check("E_post_rst_inst", qif.fpu_inst, 32'hF0000053);
    check("E_post_rst_legl", 32'(qif.fpu_is_legl), 32'd1);
    cyc();
`else
    // F: bypass of an empty queue
    qif.in_valid = 1'b1; qif.in_inst = 32'hD0028553; qif.in_intop = 32'h0000002A; #1;
    check("F_byp_legl", 32'(qif.fpu_is_legl), 32'd1);
    check("F_byp_intop", qif.fpu_from_intreg, 32'h0000002A);
    check("F_byp_inst", qif.fpu_inst, 32'hD0028553);
    cyc();
    qif.in_valid = 1'b0; #1;
    check("F_byp_count", 32'(count), 32'd0);
    qif.in_valid = 1'b1; qif.fpu_hazard = 1'b1; qif.in_inst = 32'hD1028553; #1;
    check("F_byp_stall_legl", 32'(qif.fpu_is_legl), 32'd0);
    cyc();
    qif.in_valid = 1'b0; qif.fpu_hazard = 1'b0; #1;
    check("F_stalled_queued_count", 32'(count), 32'd1);
    check("F_stalled_queued_inst", qif.fpu_inst, 32'hD1028553);
    check("F_stall_cycles", 32'(stall_cycles), 32'd1);
    cyc();
    check("F_drained_count", 32'(count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
